// File: rtl/vdic_serial_alu.sv
// Serial stack ALU: receives framed operands and commands MSB first on din,
// reduces the operand stack and returns status/result frames on dout.
module vdic_serial_alu #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_n,
    input  logic din,
    output logic dout,
    output logic dout_valid
);

    localparam int F   = DATA_W + 2;
    localparam int RW  = 2 * DATA_W;
    localparam int TXL = 3 * F;
    localparam int BCW = $clog2(F);
    localparam int SCW = $clog2(STACK_DEPTH + 1);
    localparam int TCW = $clog2(TXL);

    typedef enum logic [1:0] {
        ST_RX   = 2'd0,
        ST_EXEC = 2'd1,
        ST_TX   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [F-2:0]      rx_sr_q, rx_sr_d;
    logic [SCW-1:0]    cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] stack_q [STACK_DEPTH];
    logic [DATA_W-1:0] stack_d [STACK_DEPTH];
    logic [STACK_DEPTH-1:0] perr_q, perr_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic              cmd_perr_q, cmd_perr_d;
    logic [TXL-1:0]    tx_sr_q, tx_sr_d;
    logic [TCW-1:0]    tx_cnt_q, tx_cnt_d;

    // Frame layout: {type, payload[DATA_W-1:0], parity}, even parity overall.
    function automatic logic [F-1:0] mk_frame(input logic t, input logic [DATA_W-1:0] p);
        return {t, p, t ^ (^p)};
    endfunction

    logic [F-1:0]      rx_frame;
    logic              rx_type;
    logic [DATA_W-1:0] rx_payload;
    logic              rx_perr;

    assign rx_frame   = {rx_sr_q, din};
    assign rx_type    = rx_frame[F-1];
    assign rx_payload = rx_frame[F-2:1];
    assign rx_perr    = ^rx_frame;

    logic [7:0]    op;
    logic          hi_bad;
    logic          op_ok;
    logic          is_nop;
    logic          few;
    logic          any_perr;
    logic [7:0]    status;
    logic [RW-1:0] acc;
    logic [RW-1:0] operand;
    logic [RW-1:0] result;

    // Reduction over the occupied stack entries, oldest first.
    always_comb begin
        op       = cmd_q[7:0];
        hi_bad   = |(cmd_q >> 8);
        is_nop   = (cmd_q == '0);
        few      = (cnt_q < SCW'(2));
        any_perr = 1'b0;
        operand  = '0;
        acc      = RW'(stack_q[0]);
        case (op)
            8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20: op_ok = !hi_bad;
            default:                                  op_ok = 1'b0;
        endcase
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (SCW'(i) < cnt_q) begin
                if (perr_q[i]) any_perr = 1'b1;
                if (i > 0) begin
                    operand = RW'(stack_q[i]);
                    case (op)
                        8'h01:   acc = acc & operand;
                        8'h02:   acc = acc | operand;
                        8'h03:   acc = acc ^ operand;
                        8'h10:   acc = acc + operand;
                        8'h20:   acc = acc - operand;
                        default: acc = acc;
                    endcase
                end
            end
        end
        status    = 8'h00;
        status[6] = cmd_perr_q;
        if (!is_nop) begin
            status[0] = few;
            status[1] = ovf_q;
            status[5] = any_perr;
            status[7] = !op_ok;
        end
        // Overflow alone still yields a result over the retained operands.
        if (is_nop || status[0] || status[5] || status[6] || status[7]) begin
            result = '0;
        end else begin
            result = acc;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        stack_d    = stack_q;
        perr_d     = perr_q;
        cmd_d      = cmd_q;
        cmd_perr_d = cmd_perr_q;
        tx_sr_d    = tx_sr_q;
        tx_cnt_d   = tx_cnt_q;
        case (state_q)
            ST_RX: begin
                if (enable_n) begin
                    bit_cnt_d = '0;
                end else if (bit_cnt_q == BCW'(F - 1)) begin
                    bit_cnt_d = '0;
                    if (rx_type) begin
                        cmd_d      = rx_payload;
                        cmd_perr_d = rx_perr;
                        state_d    = ST_EXEC;
                    end else if (cnt_q == SCW'(STACK_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < STACK_DEPTH; i++) begin
                            if (SCW'(i) == cnt_q) begin
                                stack_d[i] = rx_payload;
                                perr_d[i]  = rx_perr;
                            end
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    rx_sr_d   = rx_frame[F-2:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_EXEC: begin
                tx_sr_d  = {mk_frame(1'b1, DATA_W'(status)),
                            mk_frame(1'b0, result[RW-1:DATA_W]),
                            mk_frame(1'b0, result[DATA_W-1:0])};
                tx_cnt_d = '0;
                state_d  = ST_TX;
            end
            ST_TX: begin
                if (tx_cnt_q == TCW'(TXL - 1)) begin
                    state_d  = ST_RX;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    perr_d   = '0;
                    tx_cnt_d = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    tx_sr_d  = {tx_sr_q[TXL-2:0], 1'b0};
                end
            end
            default: state_d = ST_RX;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RX;
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= '0;
            cmd_q      <= '0;
            cmd_perr_q <= 1'b0;
            tx_sr_q    <= '0;
            tx_cnt_q   <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            cmd_q      <= cmd_d;
            cmd_perr_q <= cmd_perr_d;
            tx_sr_q    <= tx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
            stack_q    <= stack_d;
        end
    end

    // dout_valid is high for the whole TX burst; dout is held low otherwise.
    assign dout_valid = (state_q == ST_TX);
    assign dout       = dout_valid & tx_sr_q[TXL-1];

endmodule

// File: doc/vdic_serial_alu.md
VDIC_SERIAL_ALU -- requirements
Module: vdic_serial_alu

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand payload width in bits; legal range 8..16.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, operand stack capacity in words; legal range 2..32.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on posedge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable_n, input, 1, active-low input-frame qualifier.
REQ-006 SHALL have port din, input, 1, serial input, MSB first.
REQ-007 SHALL have port dout, output, 1, serial output, MSB first.
REQ-008 SHALL have port dout_valid, output, 1, high while dout carries a response bit.

Function
REQ-009 SHALL use a frame of F = DATA_W+2 bits: type bit (1 = command/status, 0 = data), DATA_W payload bits, parity bit equal to XOR of type and payload (even parity over the frame).
REQ-010 SHALL sample din on each posedge clk with enable_n=0 while in state RX; a frame completes on its F-th sampled bit.
REQ-011 SHALL discard any partial frame when enable_n is sampled high mid-frame; stack contents are kept.
REQ-012 SHALL push each completed data frame onto the stack with a per-entry parity-error flag; when the stack already holds STACK_DEPTH entries, drop the frame and set the overflow flag.
REQ-013 SHALL on a completed command frame go RX -> EXEC (1 cycle) -> TX; din and enable_n are ignored in EXEC and TX.
REQ-014 SHALL decode payload[7:0] as NOP=0x00, AND=0x01, OR=0x02, XOR=0x03, ADD=0x10, SUB=0x20; payload bits above bit 7 must be zero, otherwise the command is invalid.
REQ-015 SHALL reduce over all stacked operands in arrival order: AND/OR/XOR bitwise, ADD sum, SUB first minus each subsequent; operands zero-extended and result taken modulo 2^(2*DATA_W).
REQ-016 SHALL produce result 0 for NOP with status 0x00, regardless of stack contents.
REQ-017 SHALL set status bits: 0x01 fewer than 2 operands (non-NOP), 0x02 stack overflow, 0x20 any operand parity error, 0x40 command parity error, 0x80 invalid command; bits are ORed; status placed in payload[7:0], upper payload bits 0.
REQ-018 SHALL force result to 0 whenever any of 0x01, 0x20, 0x40 or 0x80 is set; on overflow alone, compute the result on the first STACK_DEPTH operands.
REQ-019 SHALL transmit in TX three consecutive frames without gaps: status frame (type 1), result[2*DATA_W-1:DATA_W] frame (type 0), result[DATA_W-1:0] frame (type 0), each with correct parity.
REQ-020 SHALL drive dout_valid high for exactly 3*F consecutive cycles, the first being the cycle after the EXEC cycle (second posedge after the posedge sampling the command parity bit).
REQ-021 SHALL drive dout=0 whenever dout_valid=0.
REQ-022 SHALL clear stack, overflow flag and parity-error flags at TX end and return to RX.

Reset
REQ-023 SHALL on rst_n=0 immediately and asynchronously force state RX, empty stack, cleared flags and bit counter, dout=0, dout_valid=0.
REQ-024 SHALL abort any reception, EXEC or TX in progress on reset; no response frames are emitted for the aborted command.

Verification (DATA_W=8, STACK_DEPTH=8)
REQ-025 SHALL cover: data 0x03, 0x05, 0xFF then ADD -> status 0x00, result 0x0107, dout_valid high for 30 cycles.
REQ-026 SHALL cover: data 0x0A, 0x03 then SUB -> 0x0007; data 0x03, 0x0A then SUB -> 0xFFF9.
REQ-027 SHALL cover: single data 0x55 then AND -> status 0x01, result 0x0000.
REQ-028 SHALL cover: nine data 0x01 then ADD -> status 0x02, result 0x0008.
REQ-029 SHALL cover: data 0xF0, 0x3C then XOR with command parity bit flipped -> status 0x40, result 0x0000; then same frames with correct parity -> status 0x00, result 0x00CC.
REQ-030 SHALL cover: rst_n asserted on the 10th cycle of TX -> dout_valid and dout low in the same cycle; following 0x0F, 0x33 AND -> status 0x00, result 0x0003.
